jk_cmd_driver: RTL and testbench
================================

// Module: jk_cmd_driver
// PURPOSE
// - Upstream command stage for the jk_ff flip-flop: turns queued hold/reset/set/toggle requests into registered j/k drive.
// - Requests arrive over a valid/ready handshake and are buffered in a small FIFO.
// - Each request is applied for a programmable number of cycles.
// - Keeps a shadow model of the expected flip-flop output for system-level checking.
// PARAMETERS
// - DEPTH  4  FIFO entries; power of 2, >= 2
// - REP_W  4  width of the repeat field; a command is driven for rep+1 cycles
// PORTS
// - clk        in   1      clock; all state updates on the rising edge
// - rst        in   1      synchronous, active-high reset; must also reset the downstream jk_ff
// - cmd_valid  in   1      command present
// - cmd_ready  out  1      FIFO can accept a command (= !full)
// - cmd_op     in   2      00 hold, 01 reset (j=0,k=1), 10 set (j=1,k=0), 11 toggle (j=1,k=1)
// - cmd_rep    in   REP_W  extra drive cycles
// - j          out  1      registered J drive to jk_ff
// - k          out  1      registered K drive to jk_ff
// - busy       out  1      FSM in DRIVE, or FIFO not empty
// - q_model    out  1      expected jk_ff q_out, updated on the same edge as the flip-flop
// - q_in       in   1      jk_ff q_out feedback; used only under JK_DRV_CHECK_EN
// - mismatch   out  1      sticky q_in != q_model flag
// BEHAVIOUR
// - Reset (rst=1 at an edge):
//   - j=0, k=0, q_model=0, mismatch=0, busy=0.
//   - FIFO flushed: rd/wr pointers and occupancy = 0; cmd_ready=1 from the next cycle.
//   - FSM -> IDLE.
// - Reset mid-DRIVE:
//   - Drive is aborted; j/k are 0 after that edge.
//   - Queued commands are discarded.
//   - rst has priority over every other event.
// - Handshake:
//   - A command is written when cmd_valid & cmd_ready at an edge.
//   - cmd_ready = (occupancy != DEPTH).
//   - Push while full is impossible; the upstream holds cmd_* stable while cmd_valid=1 & cmd_ready=0.
// - FIFO:
//   - Entry = {op, rep}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   - Occupancy is log2(DEPTH)+1 bits.
//   - Simultaneous push and pop: occupancy is unchanged and both pointers advance.
//   - Pop only when occupancy != 0.
// - FSM: IDLE, DRIVE.
//   - IDLE:
//     - FIFO non-empty -> pop; j/k <= decode(op); cnt <= rep; go to DRIVE.
//     - Otherwise j=k=0.
//   - DRIVE:
//     - cnt != 0 -> cnt <= cnt-1; j/k held.
//     - cnt == 0 and FIFO non-empty -> pop next entry and load it on this edge (no bubble).
//     - cnt == 0 and FIFO empty -> j=k=0; go to IDLE.
// - Latency:
//   - A command accepted into an empty FIFO in IDLE at edge E drives j/k from edge E+1.
//   - It stays driven through edge E+1+rep.
//   - A push in the same cycle as an empty-FIFO check is not visible until the next cycle.
// - Shadow model (every non-reset edge, from the current registered j/k):
//   - 00 -> hold, 01 -> 0, 10 -> 1, 11 -> ~q_model.
//   - This matches the jk_ff sampling the same j/k on the same edge.
// - cnt is REP_W bits and never underflows.
// - The hold op still consumes rep+1 drive cycles with j=k=0.
// CONFIGURATION
// - JK_DRV_CHECK_EN defined:
//   - Each non-reset edge: if q_in != q_model, mismatch <= 1.
//   - mismatch stays set until rst.
// - JK_DRV_CHECK_EN undefined:
//   - mismatch tied 0; q_in ignored; no compare logic.
// TESTING
// - Reset: rst=1 for 2 edges, with cmd_valid=1 -> j=0, k=0, q_model=0, busy=0, cmd_ready=1, nothing queued.
// - Single set: op=10, rep=0, accepted at edge E -> j=1, k=0 for one cycle after E+1; j=k=0 after E+2; q_model=1 after E+2.
// - Toggle burst: op=11, rep=3 from q_model=0 -> j=k=1 for exactly 4 cycles; q_model goes 1,0,1,0; busy drops after the last cycle.
// - Back-to-back, no bubble: push reset(rep=1), set(rep=0), toggle(rep=0) -> j/k sequence 01,01,10,11, then 00; q_model ends 0.
// - Full FIFO: push DEPTH+2 commands (rep=2) continuously -> cmd_ready=0 when occupancy=DEPTH; no command lost or duplicated; executed order = push order.
// - Reset mid-DRIVE plus check: rst during the 2nd cycle of toggle rep=5 -> j=k=0 next cycle, FIFO empty; with JK_DRV_CHECK_EN, forcing q_in=~q_model for one cycle sets mismatch=1 until rst.

Source files
------------

// File: rtl/jk_cmd_driver.sv
// Command stage for a downstream jk_ff: queues hold/reset/set/toggle requests and
// drives registered j/k for rep+1 cycles each. Optional q_in checker: JK_DRV_CHECK_EN.
module jk_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [REP_W-1:0] cmd_rep,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             q_model,
  input  logic             q_in,
  output logic             mismatch
);

  // state   | meaning
  // S_IDLE  | nothing driven, waiting for the FIFO to hold an entry
  // S_DRIVE | j/k held for the loaded command while r_cnt counts down
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam int ENT_W = 2 + REP_W;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OCC_W-1:0] r_occ;

  state_t           r_state;
  logic [REP_W-1:0] r_cnt;
  logic             r_j;
  logic             r_k;
  logic             r_q_model;
  logic             r_mismatch;

  state_t           w_state_nxt;
  logic [REP_W-1:0] w_cnt_nxt;
  logic             w_j_nxt;
  logic             w_k_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_nempty;
  logic [1:0]       w_head_op;
  logic [REP_W-1:0] w_head_rep;

  assign cmd_ready  = (r_occ != OCC_W'(DEPTH));
  assign w_push     = cmd_valid & cmd_ready;
  assign w_nempty   = (r_occ != '0);
  assign w_head_op  = r_mem[r_rd_ptr][ENT_W-1 -: 2];
  assign w_head_rep = r_mem[r_rd_ptr][REP_W-1:0];

  // Storage is not reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_rep};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nempty) begin
          w_pop              = 1'b1;
          {w_j_nxt, w_k_nxt} = w_head_op;
          w_cnt_nxt          = w_head_rep;
          w_state_nxt        = S_DRIVE;
        end else begin
          w_j_nxt = 1'b0;
          w_k_nxt = 1'b0;
        end
      end
      S_DRIVE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - REP_W'(1);
        end else if (w_nempty) begin
          // Chain straight into the next entry so there is no idle cycle.
          w_pop              = 1'b1;
          {w_j_nxt, w_k_nxt} = w_head_op;
          w_cnt_nxt          = w_head_rep;
        end else begin
          w_j_nxt     = 1'b0;
          w_k_nxt     = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_j_nxt     = 1'b0;
        w_k_nxt     = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Shadow of the flip-flop: it samples the same registered j/k on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_model <= 1'b0;
    end else begin
      case ({r_j, r_k})
        2'b01:   r_q_model <= 1'b0;
        2'b10:   r_q_model <= 1'b1;
        2'b11:   r_q_model <= ~r_q_model;
        default: r_q_model <= r_q_model;
      endcase
    end
  end

`ifdef JK_DRV_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mismatch <= 1'b0;
    end else if (q_in != r_q_model) begin
      r_mismatch <= 1'b1;
    end
  end
`else
  logic w_unused_q_in;
  assign w_unused_q_in = q_in;
  assign r_mismatch    = 1'b0;
`endif

  assign j        = r_j;
  assign k        = r_k;
  assign q_model  = r_q_model;
  assign mismatch = r_mismatch;
  assign busy     = (r_state == S_DRIVE) | w_nempty;

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Bench for jk_cmd_driver: fixed vector table, directed corner sequences and
// random traffic checked each cycle against a queue-based command model.
module tb_jk_cmd_driver;
  localparam int DEPTH = 4;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [REP_W-1:0] cmd_rep = '0;
  logic             j, k, busy, q_model, mismatch;
  logic             q_in = 1'b0;

  jk_cmd_driver #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rep(cmd_rep), .j(j), .k(k), .busy(busy),
    .q_model(q_model), .q_in(q_in), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [REP_W-1:0] rep;
  } cmd_t;

  typedef struct {
    logic             rst;
    logic             valid;
    logic [1:0]       op;
    logic [REP_W-1:0] rep;
    logic             ej, ek, eqm, ebusy, erdy;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference: pending commands, the command being applied and its remaining cycles.
  cmd_t m_q[$];
  logic m_j = 1'b0, m_k = 1'b0, m_qm = 1'b0, m_mm = 1'b0;
  int   m_rem = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    cmd_t e;
    bit   rdy_pre;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_j = 1'b0; m_k = 1'b0; m_qm = 1'b0; m_mm = 1'b0; m_rem = 0;
    end else begin
      rdy_pre = (m_q.size() != DEPTH);
`ifdef JK_DRV_CHECK_EN
      if (q_in != m_qm) m_mm = 1'b1;
`endif
      if (m_j && !m_k) m_qm = 1'b1;
      else if (!m_j && m_k) m_qm = 1'b0;
      else if (m_j && m_k) m_qm = ~m_qm;
      if (m_rem > 1) begin
        m_rem--;
      end else if (m_q.size() != 0) begin
        e = m_q.pop_front();
        m_j = e.op[1]; m_k = e.op[0];
        m_rem = int'(e.rep) + 1;
      end else begin
        m_j = 1'b0; m_k = 1'b0; m_rem = 0;
      end
      if (cmd_valid && rdy_pre) begin
        e.op = cmd_op; e.rep = cmd_rep;
        m_q.push_back(e);
      end
    end
    #1;
    chk("j", int'(j), int'(m_j));
    chk("k", int'(k), int'(m_k));
    chk("q_model", int'(q_model), int'(m_qm));
    chk("busy", int'(busy), int'((m_rem > 0) || (m_q.size() != 0)));
    chk("cmd_ready", int'(cmd_ready), int'(m_q.size() != DEPTH));
    chk("mismatch", int'(mismatch), int'(m_mm));
    q_in = m_qm;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    int   n_on, ns, pushed, ops_done;
    logic prev_jk, done, saw_full, rdy;
    logic [3:0] seq;

    vecs[0] = '{1'b1, 1'b1, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 2'b01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 2'b10, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 2'b11, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with valid held high, then reset/set/toggle back-to-back.
    #2;
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; cmd_valid = vecs[i].valid;
      cmd_op = vecs[i].op; cmd_rep = vecs[i].rep;
      tick();
      chk($sformatf("vec%0d_j", i), int'(j), int'(vecs[i].ej));
      chk($sformatf("vec%0d_k", i), int'(k), int'(vecs[i].ek));
      chk($sformatf("vec%0d_q", i), int'(q_model), int'(vecs[i].eqm));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].ebusy));
      chk($sformatf("vec%0d_rdy", i), int'(cmd_ready), int'(vecs[i].erdy));
    end

    // Toggle burst rep=3 from q_model=0.
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rep = 4'd3;
    tick();
    cmd_valid = 1'b0;
    n_on = 0; ns = 0; prev_jk = 1'b0; done = 1'b0; seq = '0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (prev_jk && ns < 4) begin seq[3-ns] = q_model; ns++; end
      prev_jk = j & k;
      if (j & k) n_on++;
      if (!busy) done = 1'b1;
    end
    chk("burst_done", int'(done), 1);
    chk("burst_on_cycles", n_on, 4);
    chk("burst_q_seq", int'(seq), 4'b1010);

    // Single set rep=0.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rep = 4'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("set_j_on", int'({j, k}), 2'b10);
    tick();
    chk("set_j_off", int'({j, k}), 2'b00);
    chk("set_q", int'(q_model), 1);

    // Fill the FIFO with DEPTH+2 commands pushed continuously.
    do_reset();
    pushed = 0; saw_full = 1'b0;
    for (int c = 0; c < 200 && (pushed < DEPTH + 2 || busy); c++) begin
      if (pushed < DEPTH + 2) begin
        cmd_valid = 1'b1; cmd_op = 2'(pushed + 1); cmd_rep = 4'd2;
      end else begin
        cmd_valid = 1'b0;
      end
      rdy = cmd_ready;
      if (!rdy) saw_full = 1'b1;
      tick();
      if (cmd_valid && rdy) pushed++;
    end
    cmd_valid = 1'b0;
    chk("full_seen", int'(saw_full), 1);
    chk("full_pushed", pushed, DEPTH + 2);
    chk("full_drained", int'(busy), 0);

    // Reset during the 2nd drive cycle of toggle rep=5, with a command queued behind it.
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_rep = 4'd5;
    tick();
    cmd_op = 2'b10; cmd_rep = 4'd0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_driving", int'({j, k}), 2'b11);
    rst = 1'b1;
    tick();
    chk("abort_jk", int'({j, k}), 2'b00);
    chk("abort_busy", int'(busy), 0);
    rst = 1'b0;
    tick();
    chk("abort_flushed", int'(busy), 0);

    // One cycle of wrong feedback, then it must stick until reset.
    q_in = ~m_qm;
    tick();
    for (int c = 0; c < 3; c++) tick();
`ifdef JK_DRV_CHECK_EN
    chk("mismatch_sticky", int'(mismatch), 1);
`else
    chk("mismatch_tied", int'(mismatch), 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mismatch_cleared", int'(mismatch), 0);

    // Random traffic, upstream holding a stalled command stable.
    ops_done = 0;
    for (int c = 0; c < 600; c++) begin
      if (!(cmd_valid && !cmd_ready)) begin
        cmd_valid = ($urandom_range(0, 99) < 60);
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_rep   = 4'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 99) < 2);
      tick();
      ops_done++;
    end
    rst = 1'b0; cmd_valid = 1'b0;
    chk("random_cycles", ops_done, 600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
